// File: rtl/featuremap_pad_writer.sv
// featuremap_pad_writer
// Producer side of the featuremap input FIFO. Wraps an unpadded WIDTH x HEIGHT
// raster of 3-channel pixels with a one-pixel zero border and writes the
// resulting (WIDTH+2) x (HEIGHT+2) words into the FIFO, one word per wrreq.
//
// state | meaning
// IDLE  | waiting for a start pulse
// RUN   | walking the padded grid, one position per advance
// DONE  | single cycle after the last padded word, frame_done high
module featuremap_pad_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 112,
  parameter int HEIGHT     = 112
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3*DATA_WIDTH-1:0] pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic                    fifo_full,
  output logic                    wrreq,
  output logic [3*DATA_WIDTH-1:0] data_out,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int RW = $clog2(HEIGHT + 2);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          border;
  logic          advance;

  // State and grid position registers; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Next state, grid walk and FIFO/pixel handshakes for the current position.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    wrreq      = 1'b0;
    pix_ready  = 1'b0;
    data_out   = '0;
    frame_done = 1'b0;
    border     = (row_q == '0) || (row_q == ROW_LAST) ||
                 (col_q == '0) || (col_q == COL_LAST);
    advance    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end

      ST_RUN: begin
        // Border words need only FIFO space; interior words also need a pixel.
        advance   = !fifo_full && (border || pix_valid);
        wrreq     = advance;
        pix_ready = !border && !fifo_full;
        data_out  = border ? '0 : pix_in;
        if (advance) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = ST_DONE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

endmodule
